// File: rtl/regbank_arbiter.sv
// Round-robin arbiter that serialises read/write requests onto a shared flop bank.
// Optional REGBANK_ARB_LOCK_EN adds req_lock_i to let a requester keep the grant for up to 4 transactions.
module regbank_arbiter #(
   parameter int num_req_p = 4,
   parameter int width_p   = 8,
   parameter int depth_p   = 4,
   localparam int aw       = $clog2(depth_p),
   localparam int iw       = (num_req_p > 2) ? $clog2(num_req_p) : 1
) (
   input  logic                           clk,
   input  logic                           reset_ni,
   input  logic [num_req_p-1:0]           req_valid_i,
   input  logic [num_req_p-1:0]           req_we_i,
   input  logic [num_req_p*aw-1:0]        req_addr_i,
   input  logic [num_req_p*width_p-1:0]   req_data_i,
`ifdef REGBANK_ARB_LOCK_EN
   input  logic [num_req_p-1:0]           req_lock_i,
`endif
   output logic [num_req_p-1:0]           req_ready_o,
   output logic [depth_p-1:0]             dff_en_o,
   output logic [width_p-1:0]             dff_d_o,
   input  logic [depth_p*width_p-1:0]     dff_q_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [iw-1:0]                  rsp_id_o,
   output logic                           rsp_we_o,
   output logic [width_p-1:0]             rsp_data_o,
   output logic [1:0]                     dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // ready never depends on the transfer it would complete, and payloads are stable while valid.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [iw-1:0]      ptr_q, ptr_d;
   logic [iw-1:0]      id_q, id_d;
   logic               we_q, we_d;
   logic [aw-1:0]      addr_q, addr_d;
   logic [width_p-1:0] data_q, data_d;
   logic [width_p-1:0] rsp_data_q, rsp_data_d;
`ifdef REGBANK_ARB_LOCK_EN
   logic [1:0]         lock_cnt_q, lock_cnt_d;
`endif

   logic               found;
   logic [iw-1:0]      winner;
   logic [iw-1:0]      ptr_adv;
   int                 idx;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 0; i < num_req_p; i++) begin
         idx = (int'(ptr_q) + i) % num_req_p;
         if (!found && req_valid_i[idx]) begin
            found  = 1'b1;
            winner = iw'(idx);
         end
      end
      ptr_adv = (int'(winner) == num_req_p - 1) ? '0 : winner + 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      we_d        = we_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rsp_data_d  = rsp_data_q;
`ifdef REGBANK_ARB_LOCK_EN
      lock_cnt_d  = lock_cnt_q;
`endif
      req_ready_o = '0;
      dff_en_o    = '0;
      dff_d_o     = '0;
      rsp_valid_o = 1'b0;
      rsp_id_o    = '0;
      rsp_we_o    = 1'b0;
      rsp_data_o  = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               // Gated by reset so nothing is offered while the block is held in reset.
               req_ready_o[winner] = reset_ni;
               id_d    = winner;
               we_d    = req_we_i[winner];
               addr_d  = req_addr_i[int'(winner)*aw +: aw];
               data_d  = req_data_i[int'(winner)*width_p +: width_p];
               state_d = ACCESS;
`ifdef REGBANK_ARB_LOCK_EN
               if (req_lock_i[winner] && lock_cnt_q != 2'd3) begin
                  lock_cnt_d = lock_cnt_q + 2'd1;
                  ptr_d      = winner;
               end else begin
                  lock_cnt_d = '0;
                  ptr_d      = ptr_adv;
               end
`else
               ptr_d = ptr_adv;
`endif
            end
         end
         ACCESS: begin
            if (we_q) begin
               dff_en_o[addr_q] = 1'b1;
               dff_d_o          = data_q;
               rsp_data_d       = data_q;
            end else begin
               rsp_data_d = dff_q_i[int'(addr_q)*width_p +: width_p];
            end
            state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            rsp_id_o    = id_q;
            rsp_we_o    = we_q;
            rsp_data_o  = rsp_data_q;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
`ifdef REGBANK_ARB_LOCK_EN
         lock_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rsp_data_q <= rsp_data_d;
`ifdef REGBANK_ARB_LOCK_EN
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter with a behavioural flop bank on the dff_* ports.
module tb_regbank_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int AW = 2;
   localparam int IW = 2;

   logic            clk;
   logic            reset_ni;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    req_lock;
   logic [N-1:0]    req_ready;
   logic [D-1:0]    dff_en;
   logic [W-1:0]    dff_d;
   logic [D*W-1:0]  dff_q;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic            rsp_we;
   logic [W-1:0]    rsp_data;
   logic [1:0]      dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] bank [0:D-1] = '{8'h11, 8'h22, 8'h00, 8'h33};
   logic [W-1:0] exp_mem [0:D-1];
   int           exp_seq [0:5];

   regbank_arbiter #(.num_req_p(N), .width_p(W), .depth_p(D)) dut (
      .clk         (clk),
      .reset_ni    (reset_ni),
      .req_valid_i (req_valid),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
`ifdef REGBANK_ARB_LOCK_EN
      .req_lock_i  (req_lock),
`endif
      .req_ready_o (req_ready),
      .dff_en_o    (dff_en),
      .dff_d_o     (dff_d),
      .dff_q_i     (dff_q),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_id_o    (rsp_id),
      .rsp_we_o    (rsp_we),
      .rsp_data_o  (rsp_data),
      .dbg_state_o (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      for (int a = 0; a < D; a++) if (dff_en[a]) bank[a] <= dff_d;
   end

   always_comb begin
      for (int a = 0; a < D; a++) dff_q[a*W +: W] = bank[a];
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_data  = '0;
      req_lock  = '0;
   endtask

   initial begin
      exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'hA5; exp_mem[3] = 8'h33;
      reset_ni  = 1'b0;
      rsp_ready = 1'b0;
      clear_reqs();
      req_valid = '1;

      // reset held with every requester valid
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_ready", 32'(req_ready), 32'h0);
         check("rst_en", 32'(dff_en), 32'h0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         check("rst_state", 32'(dbg_state), 32'h0);
      end
      clear_reqs();
      reset_ni = 1'b1;

      // requester 1 writes 0xA5 to word 2
      @(negedge clk);
      req_valid = 4'b0010; req_we = 4'b0010;
      req_addr[1*AW +: AW] = 2'd2; req_data[1*W +: W] = 8'hA5;
      #1 check("wr_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      check("wr_en", 32'(dff_en), 32'h4);
      check("wr_d", 32'(dff_d), 32'hA5);
      check("wr_acc_ready", 32'(req_ready), 32'h0);
      check("wr_acc_state", 32'(dbg_state), 32'h1);
      check("wr_acc_rsp_valid", 32'(rsp_valid), 32'h0);
      req_valid = '0;
      @(negedge clk);
      check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
      check("wr_rsp_id", 32'(rsp_id), 32'h1);
      check("wr_rsp_we", 32'(rsp_we), 32'h1);
      check("wr_rsp_data", 32'(rsp_data), 32'hA5);
      check("wr_en_off", 32'(dff_en), 32'h0);
      check("wr_d_off", 32'(dff_d), 32'h0);
      check("wr_bank", 32'(bank[2]), 32'hA5);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("wr_done_state", 32'(dbg_state), 32'h0);
      check("wr_done_valid", 32'(rsp_valid), 32'h0);

      // requester 1 reads word 2 back
      req_valid = 4'b0010; req_we = 4'b0000;
      #1 check("rd_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      check("rd_en", 32'(dff_en), 32'h0);
      req_valid = '0;
      @(negedge clk);
      check("rd_rsp_id", 32'(rsp_id), 32'h1);
      check("rd_rsp_we", 32'(rsp_we), 32'h0);
      check("rd_rsp_data", 32'(rsp_data), 32'hA5);
      @(negedge clk);

      // requester 3 alone: pointer wraps back to 0 afterwards
      req_valid = 4'b1000; req_addr[3*AW +: AW] = 2'd3;
      #1 check("r3_ready", 32'(req_ready), 32'h8);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check("r3_rsp_id", 32'(rsp_id), 32'h3);
      check("r3_rsp_data", 32'(rsp_data), 32'h33);
      @(negedge clk);

      // all four valid with reads: grants 0,1,2,3,0
      req_valid = '1;
      for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = AW'(k);
      for (int g = 0; g < 5; g++) begin
         #1 check("rr_ready", 32'(req_ready), 32'(1 << (g % N)));
         @(negedge clk);
         @(negedge clk);
         check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
         check("rr_rsp_id", 32'(rsp_id), 32'(g % N));
         check("rr_rsp_data", 32'(rsp_data), 32'(exp_mem[g % N]));
         @(negedge clk);
      end
      clear_reqs();

      // backpressure: requester 1 writes 0x5C to word 0, consumer stalls 5 cycles
      rsp_ready = 1'b0;
      req_valid = 4'b0010; req_we = 4'b0010; req_data[1*W +: W] = 8'h5C;
      #1 check("bp_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      check("bp_en", 32'(dff_en), 32'h1);
      req_valid = '1;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
         check("bp_rsp_data", 32'(rsp_data), 32'h5C);
         check("bp_ready_low", 32'(req_ready), 32'h0);
         check("bp_en_low", 32'(dff_en), 32'h0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      clear_reqs();
      @(negedge clk);
      check("bp_done_state", 32'(dbg_state), 32'h0);
      check("bp_bank", 32'(bank[0]), 32'h5C);

      // reset during the write cycle of requester 2
      req_valid = 4'b0100; req_we = 4'b0100;
      req_addr[2*AW +: AW] = 2'd1; req_data[2*W +: W] = 8'h77;
      #1 check("mr_ready", 32'(req_ready), 32'h4);
      @(negedge clk);
      check("mr_en", 32'(dff_en), 32'h2);
      reset_ni = 1'b0;
      #1;
      check("mr_en_drop", 32'(dff_en), 32'h0);
      check("mr_state", 32'(dbg_state), 32'h0);
      check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
      check("mr_ready_rst", 32'(req_ready), 32'h0);
      clear_reqs();
      @(negedge clk);
      check("mr_rsp_valid2", 32'(rsp_valid), 32'h0);
      check("mr_bank", 32'(bank[1]), 32'h22);
      reset_ni = 1'b1;
      @(negedge clk);
      check("mr_rsp_valid3", 32'(rsp_valid), 32'h0);

      // pointer back at 0: requester 0 reads the untouched word 1
      req_valid = 4'b0001; req_addr[0*AW +: AW] = 2'd1;
      #1 check("pr_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check("pr_rsp_id", 32'(rsp_id), 32'h0);
      check("pr_rsp_data", 32'(rsp_data), 32'h22);
      @(negedge clk);

`ifdef REGBANK_ARB_LOCK_EN
      // requester 2 locked, everyone valid, pointer at 1: grants 1,2,2,2,2,3
      exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 2;
      exp_seq[3] = 2; exp_seq[4] = 2; exp_seq[5] = 3;
      req_valid = '1; req_lock = 4'b0100;
      for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = AW'(k);
      for (int g = 0; g < 6; g++) begin
         #1 check("lk_ready", 32'(req_ready), 32'(1 << exp_seq[g]));
         @(negedge clk);
         @(negedge clk);
         check("lk_rsp_id", 32'(rsp_id), 32'(exp_seq[g]));
         @(negedge clk);
      end
      clear_reqs();
`else
      exp_seq[0] = 0;
      check("final_idle", 32'(dbg_state), 32'(exp_seq[0]));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
